// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and default bit timing.
// Reused by the transmit controller and the future receive block.
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 10417;  // 100 MHz clock, 9600 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud down-counter: counts CLKS_PER_BIT-1 to 0 and reloads itself, giving one tick per bit.
// A load pulse forces an arbitrary preload (full bit for TX, half bit for RX centring).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] preload,
    output logic             tick
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= preload;
        end else if (count == '0) begin
            count <= CNT_W'(CLKS_PER_BIT - 1);
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame (start, 8 data LSB first, optional even parity, stop)
// per rising edge of the debounced transmit level; tx/busy are registered, done marks the last stop cycle.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   transmit,
    input  logic [UART_DATA_W-1:0] data_in,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_t                 state;
    state_t                 state_next;
    logic                   transmit_q;
    logic                   rise;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] shift_next;
    logic                   parity;
    logic                   parity_next;
    logic [2:0]             bit_idx;
    logic [2:0]             bit_next;
    logic                   stop_idx;
    logic                   stop_next;
    logic                   tx_next;
    logic                   busy_next;
    logic                   load;
    logic                   tick;

    assign rise = transmit & ~transmit_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .preload(CNT_W'(CLKS_PER_BIT - 1)),
        .tick   (tick)
    );

    // transmit_q resets high so a request held through reset release is not seen as a new edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            transmit_q <= 1'b1;
            shift      <= '0;
            parity     <= 1'b0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            transmit_q <= transmit;
            shift      <= shift_next;
            parity     <= parity_next;
            bit_idx    <= bit_next;
            stop_idx   <= stop_next;
            tx         <= tx_next;
            busy       <= busy_next;
        end
    end

    // tx_next is the line level for the coming cycle, so transitions load the first level of the next field
    always_comb begin
        state_next  = state;
        shift_next  = shift;
        parity_next = parity;
        bit_next    = bit_idx;
        stop_next   = stop_idx;
        tx_next     = tx;
        busy_next   = busy;
        load        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (rise) begin
                    shift_next  = data_in;
                    parity_next = ^data_in;
                    load        = 1'b1;
                    state_next  = START;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    bit_next   = '0;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            tx_next    = parity;
                        end else begin
                            state_next = STOP;
                            stop_next  = 1'b0;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                        shift_next = shift >> 1;
                        tx_next    = shift[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (tick) begin
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done       = 1'b1;
                    end else begin
                        stop_next = stop_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: three instances (plain, even parity, two stop bits) at 4 clks/bit,
// driven by directed and random requests; a frame-level model predicts accepted bytes and their waveforms.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] transmit;
    logic [7:0] data_in [3];
    logic [2:0] tx;
    logic [2:0] busy;
    logic [2:0] done;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .transmit(transmit[0]), .data_in(data_in[0]),
        .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .transmit(transmit[1]), .data_in(data_in[1]),
        .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .transmit(transmit[2]), .data_in(data_in[2]),
        .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    bit   prev     [3];
    int   free_at  [3];
    bit   in_frame [3];
    int   fstart   [3];
    logic [7:0] fdata [3];

    function automatic int par_en(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int stop_bits(int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic int flen(int i);
        return (10 + par_en(i) + stop_bits(i) - 1) * CPB;
    endfunction

    // expected line level at a given offset from the first start-bit cycle
    function automatic int exp_line(int i, logic [7:0] d, int off);
        int b;
        b = off / CPB;
        if (b == 0) return 0;
        if (b <= 8) return int'(d[b-1]);
        if (par_en(i) != 0 && b == 9) return int'(^d);
        return 1;
    endfunction

    task automatic check(string name, int inst, int act, int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s inst%0d cyc%0d: got %0d, expected %0d", name, inst, cyc, act, expv);
        end
    endtask

    // reference model: a request is accepted on a 0->1 level change once the previous frame plus one idle cycle is over
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                prev[i]    = 1'b1;
                free_at[i] = 0;
            end else begin
                if (transmit[i] && !prev[i] && cyc >= free_at[i]) begin
                    e.inst  = i;
                    e.data  = data_in[i];
                    e.start = cyc;
                    exp_q.push_back(e);
                    free_at[i] = cyc + flen(i) + 1;
                end
                prev[i] = transmit[i];
            end
        end
        if (!rst_n) exp_q.delete();
    end

    // monitor: claims the oldest expected frame of an instance when it leaves idle, then checks every cycle
    always @(negedge clk) begin
        int k;
        int off;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                in_frame[i] = 1'b0;
                check("reset_tx", i, int'(tx[i]), 1);
                check("reset_busy", i, int'(busy[i]), 0);
                check("reset_done", i, int'(done[i]), 0);
            end else begin
                if (!in_frame[i] && (busy[i] || !tx[i] || done[i])) begin
                    k = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (k < 0 && exp_q[j].inst == i) k = j;
                    if (k < 0) begin
                        check("unexpected_busy", i, int'(busy[i]), 0);
                        check("unexpected_tx", i, int'(tx[i]), 1);
                        check("unexpected_done", i, int'(done[i]), 0);
                    end else begin
                        check("start_cycle", i, cyc, exp_q[k].start);
                        fdata[i]    = exp_q[k].data;
                        fstart[i]   = cyc;
                        in_frame[i] = 1'b1;
                        exp_q.delete(k);
                    end
                end
                if (in_frame[i]) begin
                    off = cyc - fstart[i];
                    if (off < flen(i)) begin
                        check("tx_line", i, int'(tx[i]), exp_line(i, fdata[i], off));
                        check("busy_in_frame", i, int'(busy[i]), 1);
                        check("done_pulse", i, int'(done[i]), (off == flen(i) - 1) ? 1 : 0);
                    end else begin
                        check("end_busy", i, int'(busy[i]), 0);
                        check("end_tx", i, int'(tx[i]), 1);
                        check("end_done", i, int'(done[i]), 0);
                        in_frame[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (cyc + 1 < free_at[i] && n < 2000) begin
            step();
            n++;
        end
        check("ready_timeout", i, (n < 2000) ? 1 : 0, 1);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc + 1 < target) step();
    endtask

    // raises transmit so the DUT samples the rise at cycle r; leaves transmit high when hold is set
    task automatic send(input int i, input logic [7:0] d, input bit hold, output int r);
        transmit[i] = 1'b0;
        step();
        wait_ready(i);
        transmit[i] = 1'b1;
        data_in[i]  = d;
        step();
        r = cyc;
        if (!hold) transmit[i] = 1'b0;
        data_in[i] = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        rst_n    = 1'b0;
        transmit = '0;
        for (int i = 0; i < 3; i++) data_in[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // reference bytes from the plan, plus a two-stop-bit frame
        send(0, 8'hA5, 1'b0, r);
        send(1, 8'h07, 1'b0, r);
        send(1, 8'h03, 1'b0, r);
        send(2, 8'h5A, 1'b0, r);
        for (int i = 0; i < 3; i++) begin
            transmit[i] = 1'b0;
            wait_ready(i);
        end

        // level held across the whole frame while data_in keeps changing
        send(0, 8'h3C, 1'b1, r);
        repeat (flen(0) + 10) begin
            data_in[0] = 8'($urandom);
            step();
        end
        transmit[0] = 1'b0;
        step();

        // rise mid-frame, then a rise landing on the done cycle: both dropped
        send(0, 8'($urandom), 1'b0, r);
        repeat (5) step();
        transmit[0] = 1'b1;
        repeat (3) step();
        transmit[0] = 1'b0;
        wait_cycle(r + flen(0));
        transmit[0] = 1'b1;
        step();
        step();
        transmit[0] = 1'b0;
        repeat (flen(0)) step();
        check("done_cycle_rise_ignored", 0, int'(busy[0]), 0);

        // rise one cycle after done: back-to-back frames with a single idle cycle
        send(0, 8'hC3, 1'b0, r);
        wait_cycle(r + flen(0) + 1);
        transmit[0] = 1'b1;
        data_in[0]  = 8'h96;
        step();
        transmit[0] = 1'b0;
        wait_ready(0);

        // reset during data bit 3 with the request still held high
        wait_ready(1);
        wait_ready(2);
        send(0, 8'hF0, 1'b1, r);
        wait_cycle(r + CPB * 4 + 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", 0, int'(tx[0]), 1);
        check("async_reset_busy", 0, int'(busy[0]), 0);
        check("async_reset_done", 0, int'(done[0]), 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (flen(0) + 10) step();
        check("no_frame_after_reset", 0, int'(busy[0]), 0);
        transmit[0] = 1'b0;
        step();

        // random request levels and data on all instances
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) transmit[i] = ~transmit[i];
                data_in[i] = 8'($urandom);
            end
            step();
        end
        transmit = '0;
        repeat (flen(2) + 10) step();

        check("expected_frames_left", 0, exp_q.size(), 0);
        for (int i = 0; i < 3; i++) check("frame_open_at_end", i, int'(in_frame[i]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Sequences one UART transmit frame per press of the debounced `transmit` level from the button debouncer. On each rising edge it samples an 8-bit byte from `data_in` and serialises it on `tx`: start bit, 8 data bits LSB first, optional even parity bit, then stop bit. It sits between the debouncer and the board TX pin and owns bit timing, framing and the busy/done handshake toward the rest of the design.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); legal values >= 2
PARITY_EN, 0, 1 inserts an even-parity bit between the last data bit and the stop bit
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
transmit  input  1  debounced request level; a 0->1 transition requests one frame
data_in  input  8  byte to send; sampled only on the accepted request cycle
tx  output  1  serial line; idles high
busy  output  1  high from frame start until the end of the last stop bit
done  output  1  single-cycle pulse when a frame completes

Behaviour:
- Reset (async assert, sync release to clk): tx=1, busy=0, done=0, state=IDLE, bit and baud counters=0, shift register=0, transmit_q=1. transmit_q resets to 1 so that a request held high through reset release does not start a frame.
- Edge detect: transmit_q<=transmit every cycle. rise = transmit & ~transmit_q.
- States:
  - IDLE: tx=1, busy=0. On rise: latch data_in, load baud counter, go to START. Registered outputs tx=0 and busy=1 appear on the next cycle, so latency from rise to start bit is 1 clk.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle: state=IDLE, busy=0, done=1 for exactly 1 cycle.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) * CLKS_PER_BIT cycles, measured from the first tx=0 cycle to the first cycle with busy=0.
- Baud counter: counts CLKS_PER_BIT-1 down to 0; the bit advances when it reaches 0. Width is $clog2(CLKS_PER_BIT). No drift across bits.
- Rise while busy: ignored and not queued. transmit_q still tracks the input, so a level held across frame end does not retrigger.
- Rise on the same cycle done pulses: ignored, because the state is still STOP on that cycle. A rise on the cycle after done is accepted, giving back-to-back frames with 1 idle-high cycle between them.
- data_in changes mid-frame: no effect; only the latched copy is serialised.
- Reset mid-frame: tx returns high immediately and asynchronously. The frame is aborted, no done pulse is issued, and the partial frame is not resumed.
- tx is driven from a flop with no combinational path from any input.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP}
  - UART_DATA_W=8
  - default CLKS_PER_BIT constant
  - these are reused by the future RX block.
- One natural sub-module: uart_baud_gen (baud down-counter with load input and tick output, CLKS_PER_BIT parameter). RX will reuse it with a half-bit preload.
- Edge detect and FSM stay inline.

Test Plan:
- Reset, then rise on transmit with data_in=8'hA5, CLKS_PER_BIT=4, PARITY_EN=0 -> tx=0 1 clk later, then bits 1,0,1,0,0,1,0,1 at 4 clks each, stop high 4 clks; busy high 40 clks; done one 1-clk pulse.
- PARITY_EN=1, data_in=8'h07 -> parity bit=1 after bit 7; frame is 44 clks at CLKS_PER_BIT=4. Repeat with data_in=8'h03 -> parity bit=0.
- Hold transmit high across a whole frame and into idle, then toggle data_in mid-frame -> exactly one frame, carrying the byte latched at the rise.
- Second rise mid-frame; then a rise on the done cycle; then a rise 1 clk after done -> the first two are dropped, the third starts a frame with exactly 1 idle-high cycle between frames.
- Assert rst_n=0 during DATA bit 3 -> tx=1 in the same cycle (async), busy=0, no done pulse. Keep transmit high through reset release -> no frame starts.
- STOP_BITS=2, CLKS_PER_BIT=4 -> stop high for 8 clks; done aligns with the last stop cycle; frame is 44 clks.
